// File: rtl/mask_centroid.sv
// Masked-pixel centroid: accumulates coordinates of flagged pixels over a frame, then
// divides by the pixel count with two parallel restoring dividers. Optional macro COM_MIN_COUNT_EN.
module mask_centroid #(
  parameter int H_W       = 11,
  parameter int V_W       = 10,
  parameter int COUNT_W   = 20,
  parameter int SUM_W     = 32,
  parameter int MIN_COUNT = 16
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic [H_W-1:0] x_in,
  input  logic [V_W-1:0] y_in,
  input  logic           valid_in,
  input  logic           tabulate_in,
  output logic [H_W-1:0] x_out,
  output logic [V_W-1:0] y_out,
  output logic           valid_out,
  output logic           busy_out
);

  localparam int ITER_W = (SUM_W > 1) ? $clog2(SUM_W) : 1;
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(SUM_W - 1);

`ifdef COM_MIN_COUNT_EN
  // Frames with fewer masked pixels than this are treated as speckle and dropped.
  localparam logic [COUNT_W-1:0] MIN_THR = COUNT_W'((MIN_COUNT > 1) ? MIN_COUNT : 1);
`else
  localparam logic [COUNT_W-1:0] MIN_THR = COUNT_W'((MIN_COUNT > 1) ? 1 : 1);
`endif

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    DIVIDE = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SUM_W-1:0]   sum_x_q, sum_x_d, sum_y_q, sum_y_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [H_W-1:0]     x_out_q, x_out_d;
  logic [V_W-1:0]     y_out_q, y_out_d;

  logic [SUM_W-1:0]   dvd_x_q, dvd_x_d, dvd_y_q, dvd_y_d;
  logic [COUNT_W-1:0] rem_x_q, rem_x_d, rem_y_q, rem_y_d;
  logic [COUNT_W-1:0] dvs_q, dvs_d;
  logic [ITER_W-1:0]  iter_q, iter_d;

  logic [SUM_W-1:0]   sum_x_acc, sum_y_acc;
  logic [COUNT_W-1:0] count_acc;
  logic [COUNT_W:0]   step_x, step_y;
  logic [SUM_W-1:0]   quo_x, quo_y;

  // One restoring-division step: returns {quotient bit, new remainder}.
  function automatic logic [COUNT_W:0] div_step(input logic [COUNT_W-1:0] rem,
                                                input logic               msb,
                                                input logic [COUNT_W-1:0] dvs);
    logic [COUNT_W:0] trial;
    logic [COUNT_W:0] diff;
    trial = {rem, msb};
    diff  = trial - {1'b0, dvs};
    if (trial >= {1'b0, dvs}) begin
      div_step = {1'b1, diff[COUNT_W-1:0]};
    end else begin
      div_step = {1'b0, trial[COUNT_W-1:0]};
    end
  endfunction

  always_comb begin
    sum_x_acc = sum_x_q + (valid_in ? SUM_W'(x_in) : '0);
    sum_y_acc = sum_y_q + (valid_in ? SUM_W'(y_in) : '0);
    count_acc = (valid_in && (count_q != '1)) ? count_q + 1'b1 : count_q;
    step_x    = div_step(rem_x_q, dvd_x_q[SUM_W-1], dvs_q);
    step_y    = div_step(rem_y_q, dvd_y_q[SUM_W-1], dvs_q);
    quo_x     = {dvd_x_q[SUM_W-2:0], step_x[COUNT_W]};
    quo_y     = {dvd_y_q[SUM_W-2:0], step_y[COUNT_W]};
  end

  always_comb begin
    state_d = state_q;
    sum_x_d = sum_x_q;
    sum_y_d = sum_y_q;
    count_d = count_q;
    x_out_d = x_out_q;
    y_out_d = y_out_q;
    dvd_x_d = dvd_x_q;
    dvd_y_d = dvd_y_q;
    rem_x_d = rem_x_q;
    rem_y_d = rem_y_q;
    dvs_d   = dvs_q;
    iter_d  = iter_q;
    case (state_q)
      ACCUM: begin
        sum_x_d = sum_x_acc;
        sum_y_d = sum_y_acc;
        count_d = count_acc;
        if (tabulate_in) begin
          sum_x_d = '0;
          sum_y_d = '0;
          count_d = '0;
          if (count_acc >= MIN_THR) begin
            dvd_x_d = sum_x_acc;
            dvd_y_d = sum_y_acc;
            dvs_d   = count_acc;
            rem_x_d = '0;
            rem_y_d = '0;
            iter_d  = '0;
            state_d = DIVIDE;
          end
        end
      end
      DIVIDE: begin
        // Quotient bits shift into the dividend register as its bits are consumed.
        dvd_x_d = quo_x;
        dvd_y_d = quo_y;
        rem_x_d = step_x[COUNT_W-1:0];
        rem_y_d = step_y[COUNT_W-1:0];
        iter_d  = iter_q + 1'b1;
        if (iter_q == LAST_ITER) begin
          x_out_d = quo_x[H_W-1:0];
          y_out_d = quo_y[V_W-1:0];
          state_d = OUTPUT;
        end
      end
      OUTPUT: begin
        sum_x_d = sum_x_acc;
        sum_y_d = sum_y_acc;
        count_d = count_acc;
        state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= ACCUM;
      sum_x_q <= '0;
      sum_y_q <= '0;
      count_q <= '0;
      x_out_q <= '0;
      y_out_q <= '0;
    end else begin
      state_q <= state_d;
      sum_x_q <= sum_x_d;
      sum_y_q <= sum_y_d;
      count_q <= count_d;
      x_out_q <= x_out_d;
      y_out_q <= y_out_d;
    end
  end

  // Divider datapath is always loaded before use, so it carries no reset.
  always_ff @(posedge clk_in) begin
    dvd_x_q <= dvd_x_d;
    dvd_y_q <= dvd_y_d;
    rem_x_q <= rem_x_d;
    rem_y_q <= rem_y_d;
    dvs_q   <= dvs_d;
    iter_q  <= iter_d;
  end

  assign x_out     = x_out_q;
  assign y_out     = y_out_q;
  assign valid_out = (state_q == OUTPUT);
  assign busy_out  = (state_q == DIVIDE);

endmodule

// File: tb/tb_mask_centroid.sv
// Self-checking bench for mask_centroid: directed frames plus randomized pixel/strobe traffic
// against a timeline-based reference of the centroid behaviour.
module tb_mask_centroid;
  localparam int H_W     = 11;
  localparam int V_W     = 10;
  localparam int COUNT_W = 20;
  localparam int SUM_W   = 32;
`ifdef COM_MIN_COUNT_EN
  localparam longint MINC = 16;
`else
  localparam longint MINC = 1;
`endif
  localparam longint CMAX = (64'd1 << COUNT_W) - 1;

  logic           clk_in = 1'b0;
  logic           rst_in = 1'b0;
  logic [H_W-1:0] x_in = '0;
  logic [V_W-1:0] y_in = '0;
  logic           valid_in = 1'b0;
  logic           tabulate_in = 1'b0;
  logic [H_W-1:0] x_out;
  logic [V_W-1:0] y_out;
  logic           valid_out;
  logic           busy_out;

  mask_centroid #(.H_W(H_W), .V_W(V_W), .COUNT_W(COUNT_W), .SUM_W(SUM_W), .MIN_COUNT(16)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .x_in(x_in), .y_in(y_in),
    .valid_in(valid_in), .tabulate_in(tabulate_in),
    .x_out(x_out), .y_out(y_out), .valid_out(valid_out), .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;

  // Reference: frame sums, and the edge at which the last accepted tabulate was sampled.
  longint m_sx = 0, m_sy = 0, m_cnt = 0;
  longint e = 0, e0 = -1;
  longint m_rx = 0, m_ry = 0, m_x = 0, m_y = 0;
  bit     m_valid = 1'b0, m_busy = 1'b0;
  int     npulse = 0;
  longint cap_x = 0, cap_y = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit v, input bit t, input int x, input int y);
    rst_in      = r;
    valid_in    = v;
    tabulate_in = t;
    x_in        = x[H_W-1:0];
    y_in        = y[V_W-1:0];
    @(posedge clk_in);
    e++;
    if (!r) begin
      m_sx = 0; m_sy = 0; m_cnt = 0; e0 = -1; m_x = 0; m_y = 0;
    end else if (e0 >= 0 && e > e0 && e <= e0 + SUM_W) begin
      // divider running: pixel and strobe are lost
    end else begin
      if (v) begin
        m_sx += x; m_sy += y;
        if (m_cnt < CMAX) m_cnt++;
      end
      if (t && !(e0 >= 0 && e == e0 + SUM_W + 1)) begin
        if (m_cnt >= MINC) begin
          e0   = e;
          m_rx = m_sx / m_cnt;
          m_ry = m_sy / m_cnt;
        end
        m_sx = 0; m_sy = 0; m_cnt = 0;
      end
    end
    m_busy  = (e0 >= 0) && (e >= e0) && (e < e0 + SUM_W);
    m_valid = (e0 >= 0) && (e == e0 + SUM_W);
    if (m_valid) begin
      m_x = m_rx; m_y = m_ry;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 0, 0);
  endtask

  // Every cycle, outputs must match the reference.
  always @(negedge clk_in) begin
    chk("valid_out", valid_out, m_valid);
    chk("busy_out", busy_out, m_busy);
    chk("x_out", x_out, m_x);
    chk("y_out", y_out, m_y);
    if (valid_out === 1'b1) begin
      npulse++;
      cap_x = x_out;
      cap_y = y_out;
    end
  end

  initial begin
    step(1'b0, 1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 0, 0);
    chk("reset_x", x_out, 0);
    chk("reset_busy", busy_out, 0);

`ifndef COM_MIN_COUNT_EN
    npulse = 0;
    step(1'b1, 1'b1, 1'b0, 100, 50);
    step(1'b1, 1'b0, 1'b1, 0, 0);
    idle(31);
    chk("single_not_yet", npulse, 0);
    idle(3);
    chk("single_pulses", npulse, 1);
    chk("single_x", cap_x, 100);
    chk("single_y", cap_y, 50);
    chk("single_model_x", m_rx, 100);

    step(1'b1, 1'b1, 1'b0, 0, 0);
    step(1'b1, 1'b1, 1'b0, 10, 0);
    step(1'b1, 1'b1, 1'b0, 0, 20);
    step(1'b1, 1'b1, 1'b1, 10, 20);
    idle(34);
    chk("square_x", cap_x, 5);
    chk("square_y", cap_y, 10);

    step(1'b1, 1'b1, 1'b0, 1, 0);
    step(1'b1, 1'b1, 1'b1, 2, 0);
    idle(34);
    chk("floor_x", cap_x, 1);
    chk("floor_y", cap_y, 0);
    npulse = 0;
    step(1'b1, 1'b0, 1'b1, 0, 0);
    idle(34);
    chk("empty_pulses", npulse, 0);
    chk("empty_hold_x", x_out, 1);
    chk("empty_hold_y", y_out, 0);

    // Full 1024x768 extent: both edge columns of every row.
    for (int yy = 0; yy < 768; yy++) begin
      step(1'b1, 1'b1, 1'b0, 0, yy);
      step(1'b1, 1'b1, (yy == 767), 1023, yy);
    end
    idle(34);
    chk("frame_x", cap_x, 511);
    chk("frame_y", cap_y, 383);

    npulse = 0;
    step(1'b1, 1'b1, 1'b0, 3, 4);
    step(1'b1, 1'b0, 1'b1, 0, 0);
    idle(9);
    step(1'b0, 1'b0, 1'b0, 0, 0);
    idle(34);
    chk("abort_pulses", npulse, 0);
    chk("abort_x", x_out, 0);
    chk("abort_y", y_out, 0);
    chk("abort_busy", busy_out, 0);
    step(1'b1, 1'b1, 1'b0, 7, 9);
    step(1'b1, 1'b0, 1'b1, 0, 0);
    idle(34);
    chk("after_abort_x", cap_x, 7);
    chk("after_abort_y", cap_y, 9);
`else
    npulse = 0;
    for (int i = 0; i < 15; i++) step(1'b1, 1'b1, 1'b0, 40, 40);
    step(1'b1, 1'b0, 1'b1, 0, 0);
    idle(34);
    chk("min15_pulses", npulse, 0);
    chk("min15_x", x_out, 0);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b0, 40, 40);
    step(1'b1, 1'b0, 1'b1, 0, 0);
    idle(34);
    chk("min16_pulses", npulse, 1);
    chk("min16_x", cap_x, 40);
    chk("min16_y", cap_y, 40);
`endif

    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 299) != 0),
           ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 39) == 0),
           int'($urandom_range(0, (1 << H_W) - 1)),
           int'($urandom_range(0, (1 << V_W) - 1)));
    end
    idle(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=%0d required=%0d", total, 0);
    $fatal(1, "timeout");
  end
endmodule
